// File: rtl/bus_dev_pkg.sv
// rtl/bus_dev_pkg.sv - shared constants and helpers for the bus device port
//
// Contents:
//   ID_W      width of a bus destination ID
//   BCAST_ID  destination ID that every device accepts
//   dest_id() extracts the destination ID (top ID_W bits) of a packet
package bus_dev_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  // pkt is the packet zero-extended to 64 bits and width is its real width.
  // Shifting the whole word down keeps every input bit in use.
  function automatic logic [ID_W-1:0] dest_id(input logic [63:0] pkt,
                                              input int unsigned width);
    return ID_W'(pkt >> (width - ID_W));
  endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// rtl/bus_dev_fifo.sv - synchronous FIFO with count-based full/empty
//
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   push, din    enqueue din; accepted when not full, or when full with a pop
//   pop          dequeue head; ignored when empty
//   dout         head entry, forced to 0 while empty
//   full, empty  occupancy flags decoded from the registered count
module bus_dev_fifo
  import bus_dev_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: dout is masked whenever the count says empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/bus_device_port.sv
// rtl/bus_device_port.sv - device-side endpoint of the broadcast bus
//
// Optional feature macro: BUS_DEV_ADDR_FILTER_EN (RX destination filter).
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   host_push/host_din  host enqueues into TX; tx_full flags a full TX queue
//   host_pop/host_dout  host drains RX head; rx_empty flags an empty RX queue
//   pndng/D_pop         TX non-empty and TX head, presented to the bus
//   pop                 bus consumes the TX head
//   push/D_push         bus delivers a packet to this drop
//   rx_drop_cnt         saturating count of packets lost to a full RX queue
//   tx_err              sticky: pop on empty TX, or push on full TX without pop
module bus_device_port
  import bus_dev_pkg::*;
#(
  parameter int unsigned      pckg_sz   = 16,
  parameter int unsigned      deep_fifo = 8,
  parameter logic [ID_W-1:0]  id        = 8'd0,
  parameter logic [ID_W-1:0]  bcast     = BCAST_ID
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               host_push,
  input  logic [pckg_sz-1:0] host_din,
  output logic               tx_full,
  input  logic               host_pop,
  output logic [pckg_sz-1:0] host_dout,
  output logic               rx_empty,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic [7:0]         rx_drop_cnt,
  output logic               tx_err
);

`ifdef BUS_DEV_ADDR_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic            tx_empty;
  logic            rx_full;
  logic [ID_W-1:0] rx_dest;
  logic            addr_match;
  logic            rx_accept;
  logic            rx_drop;

  bus_dev_fifo #(.W(pckg_sz), .DEPTH(deep_fifo)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host_push),
    .din   (host_din),
    .pop   (pop),
    .dout  (D_pop),
    .full  (tx_full),
    .empty (tx_empty)
  );

  assign pndng = !tx_empty;

  assign rx_dest    = dest_id(64'(D_push), pckg_sz);
  assign addr_match = (rx_dest == id) || (rx_dest == bcast);
  // Promiscuous unless the filter is built in: non-matching pushes vanish
  // silently and never reach the drop counter.
  assign rx_accept  = push && (!FILTER_ON || addr_match);
  assign rx_drop    = rx_accept && rx_full && !host_pop;

  bus_dev_fifo #(.W(pckg_sz), .DEPTH(deep_fifo)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_accept),
    .din   (D_push),
    .pop   (host_pop),
    .dout  (host_dout),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_drop_cnt <= 8'd0;
      tx_err      <= 1'b0;
    end else begin
      if (rx_drop && (rx_drop_cnt != 8'hFF)) rx_drop_cnt <= rx_drop_cnt + 8'd1;
      // A pop frees a full queue, so only a push without a pop is an overflow.
      if ((pop && tx_empty) || (host_push && tx_full && !pop)) tx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_device_port.sv
// tb/tb_bus_device_port.sv - directed self-checking bench for bus_device_port
module tb_bus_device_port;

`ifdef BUS_DEV_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        host_push;
  logic [15:0] host_din;
  logic        tx_full;
  logic        host_pop;
  logic [15:0] host_dout;
  logic        rx_empty;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic [7:0]  rx_drop_cnt;
  logic        tx_err;

  int checks = 0;
  int errors = 0;

  bus_device_port #(.pckg_sz(16), .deep_fifo(8), .id(8'd3), .bcast(8'hFF)) dut (
    .clk         (clk),
    .reset       (reset),
    .host_push   (host_push),
    .host_din    (host_din),
    .tx_full     (tx_full),
    .host_pop    (host_pop),
    .host_dout   (host_dout),
    .rx_empty    (rx_empty),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .rx_drop_cnt (rx_drop_cnt),
    .tx_err      (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hp;
    logic [15:0] hd;
    logic        hpop;
    logic        bpop;
    logic        bpush;
    logic [15:0] dp;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic        e_rxe;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_push = 1'b0;
    host_pop  = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
  endtask

  initial begin
    // TX: push 0311, 0522 then two bus pops. RX: 03AA, 07BB, FFCC then drain.
    tbl[0] = '{1'b1, 16'h0311, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0311, 1'b1, 16'h0000};
    tbl[1] = '{1'b1, 16'h0522, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0311, 1'b1, 16'h0000};
    tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0522, 1'b1, 16'h0000};
    tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h03AA, 1'b0, 16'h0000, 1'b0, 16'h03AA};
    tbl[5] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h07BB, 1'b0, 16'h0000, 1'b0, 16'h03AA};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFCC, 1'b0, 16'h0000, 1'b0, 16'h03AA};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0,
               FILT ? 16'hFFCC : 16'h07BB};
    tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, FILT,
               FILT ? 16'h0000 : 16'hFFCC};
    tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000};

    // 1: reset with host_push held
    reset = 1'b0; idle(); host_push = 1'b1; host_din = 16'h0042; D_push = 16'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_pndng", 32'(pndng), 32'd0);
      chk("rst_rx_empty", 32'(rx_empty), 32'd1);
      chk("rst_drop", 32'(rx_drop_cnt), 32'd0);
    end
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_dpop", 32'(D_pop), 32'd0);
    chk("rst_dout", 32'(host_dout), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    reset = 1'b1;
    step();
    chk("first_push_pndng", 32'(pndng), 32'd1);
    chk("first_push_dpop", 32'(D_pop), 32'h0042);
    host_push = 1'b0; pop = 1'b1;
    step();
    pop = 1'b0;
    chk("first_pop_pndng", 32'(pndng), 32'd0);

    // 2 and 3: table
    for (int i = 0; i < 10; i++) begin
      host_push = tbl[i].hp;  host_din = tbl[i].hd; host_pop = tbl[i].hpop;
      pop = tbl[i].bpop;      push = tbl[i].bpush;  D_push = tbl[i].dp;
      step();
      chk($sformatf("v%0d_pndng", i), 32'(pndng), 32'(tbl[i].e_pndng));
      chk($sformatf("v%0d_dpop", i), 32'(D_pop), 32'(tbl[i].e_dpop));
      chk($sformatf("v%0d_rx_empty", i), 32'(rx_empty), 32'(tbl[i].e_rxe));
      chk($sformatf("v%0d_dout", i), 32'(host_dout), 32'(tbl[i].e_dout));
    end
    idle();
    chk("tbl_tx_err", 32'(tx_err), 32'd0);

    // 4: RX overflow and drop counter
    push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      D_push = 16'h0300 + 16'(i);
      step();
    end
    D_push = 16'h0388; step();
    chk("drop_1", 32'(rx_drop_cnt), 32'd1);
    D_push = 16'h0399; step();
    chk("drop_2", 32'(rx_drop_cnt), 32'd2);
    D_push = 16'h03EE; host_pop = 1'b1; step();
    chk("full_pop_drop", 32'(rx_drop_cnt), 32'd2);
    chk("full_pop_head", 32'(host_dout), 32'h0301);
    push = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rx_drain%0d", k), 32'(host_dout),
          32'((k < 7) ? (16'h0301 + 16'(k)) : 16'h03EE));
      step();
    end
    host_pop = 1'b0;
    chk("rx_drained", 32'(rx_empty), 32'd1);
    chk("rx_tx_err", 32'(tx_err), 32'd0);

    // 5: TX full with simultaneous push/pop, then pop on empty
    host_push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_din = 16'h0100 + 16'(i);
      step();
    end
    chk("tx_full_8", 32'(tx_full), 32'd1);
    host_din = 16'h01AA; pop = 1'b1; step();
    chk("pp_full", 32'(tx_full), 32'd1);
    chk("pp_err", 32'(tx_err), 32'd0);
    host_push = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tx_drain%0d", k), 32'(D_pop),
          32'((k < 7) ? (16'h0101 + 16'(k)) : 16'h01AA));
      step();
    end
    pop = 1'b0;
    chk("tx_drained", 32'(pndng), 32'd0);
    chk("tx_drained_err", 32'(tx_err), 32'd0);
    pop = 1'b1; step(); pop = 1'b0;
    chk("empty_pop_err", 32'(tx_err), 32'd1);

    // 6: asynchronous reset mid-stream
    host_push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_din = 16'h0200 + 16'(i);
      push = (i < 3);
      D_push = 16'h0300 + 16'(i);
      step();
    end
    idle();
    chk("pre_rst_pndng", 32'(pndng), 32'd1);
    chk("pre_rst_rx_empty", 32'(rx_empty), 32'd0);
    #2 reset = 1'b0;
    #1;
    chk("async_pndng", 32'(pndng), 32'd0);
    chk("async_rx_empty", 32'(rx_empty), 32'd1);
    chk("async_dpop", 32'(D_pop), 32'd0);
    chk("async_dout", 32'(host_dout), 32'd0);
    chk("async_tx_err", 32'(tx_err), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("post_rst_pndng", 32'(pndng), 32'd0);
    chk("post_rst_dpop", 32'(D_pop), 32'd0);
    chk("post_rst_rx_empty", 32'(rx_empty), 32'd1);
    host_push = 1'b1; host_din = 16'h0999; step(); host_push = 1'b0;
    chk("fresh_dpop", 32'(D_pop), 32'h0999);
    pop = 1'b1; step(); pop = 1'b0;
    chk("fresh_popped", 32'(pndng), 32'd0);

    // Overflow push on full TX without pop
    host_push = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_din = 16'h0400 + 16'(i);
      step();
    end
    chk("ovf_pre_err", 32'(tx_err), 32'd0);
    host_din = 16'h04FF; step(); host_push = 1'b0;
    chk("ovf_err", 32'(tx_err), 32'd1);
    chk("ovf_full", 32'(tx_full), 32'd1);
    chk("ovf_head", 32'(D_pop), 32'h0400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_device_port.md
Name: bus_device_port

Overview:
- Device-side endpoint of the broadcast bus generator/arbiter.
- Presents a TX queue to the bus through pndng/D_pop and dequeues on the bus's pop.
- Accepts bus deliveries on push/D_push into an RX queue that the local host drains.
- One instance per bus drop; it is the bus-facing counterpart to the arbiter.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID, the rest is payload.
- deep_fifo, 8, depth of each of the TX and RX queues; power of two, at least 2.
- id, 0, this device's 8-bit bus ID.
- bcast, 8'hFF, broadcast destination ID.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- host_push  in  1  enqueue host_din into TX.
- host_din  in  pckg_sz  TX data from host.
- tx_full  out  1  TX holds deep_fifo entries.
- host_pop  in  1  dequeue RX head.
- host_dout  out  pckg_sz  RX head (valid while rx_empty=0).
- rx_empty  out  1  RX holds 0 entries.
- pndng  out  1  TX non-empty, to bus.
- D_pop  out  pckg_sz  TX head, to bus.
- pop  in  1  bus consumes TX head this cycle.
- push  in  1  bus delivers D_push this cycle.
- D_push  in  pckg_sz  delivered packet.
- rx_drop_cnt  out  8  saturating count of RX packets dropped because RX was full.
- tx_err  out  1  sticky; set by pop while TX empty or host_push while full without a simultaneous pop.

Behaviour:
- Reset (reset=0, async): both queues empty and pointers 0. pndng=0, tx_full=0, rx_empty=1, D_pop=0, host_dout=0, rx_drop_cnt=0, tx_err=0.
- pndng=!tx_empty and D_pop=TX head are decoded from registered state, so they are glitch-free and change only after a clock edge.
- Bus pop with pndng=1: head advances at that edge. The next entry is visible on D_pop in the following cycle, and pndng drops in the following cycle if the queue emptied.
- Bus pop with pndng=0: ignored, state unchanged, tx_err set.
- host_push with TX not full: entry written at that edge.
- host_push with TX full and no pop: data dropped, tx_err set.
- host_push and pop in the same cycle while full: both take effect and the count is unchanged.
- Same-cycle host_push and pop while empty: push is accepted, pop is rejected and sets tx_err, count becomes 1.
- RX accepts D_push when push=1 and the destination ID equals id or bcast (see Optional Feature).
- Accepted packet while RX full and no host_pop that cycle: packet dropped, rx_drop_cnt increments and saturates at 255.
- Accepted packet while RX full with host_pop the same cycle: packet is stored.
- host_pop with rx_empty=1: ignored, no error flag.
- RX latency: a packet pushed at edge N appears on host_dout after edge N, and rx_empty=0 in cycle N+1.
- Pointers are log2(deep_fifo) bits wide and wrap naturally. Full/empty are resolved with an occupancy counter of log2(deep_fifo)+1 bits.
- Reset asserted mid-operation discards all queued data immediately; no partial packet is retained.

Optional Feature:
- Macro: BUS_DEV_ADDR_FILTER_EN.
- Defined: RX accepts only packets whose destination ID equals id or bcast; all other pushes are silently ignored and do not count as drops.
- Undefined: every push is accepted (promiscuous mode), for bus monitoring and bring-up.

Decomposition:
- Package bus_dev_pkg: ID_W=8, BCAST_ID=8'hFF, and function dest_id(pkt) returning the top 8 bits.
- Sub-module bus_dev_fifo: synchronous FIFO with count-based full/empty and same-cycle push/pop. It is instantiated twice, for TX and RX.

Test Plan:
1. Reset with host_push=1 held -> pndng=0, rx_empty=1, rx_drop_cnt=0 throughout reset. After release, the first push gives pndng=1 one cycle later.
2. Host pushes 16'h0311, 16'h0522, then the bus pops twice -> D_pop shows 16'h0311 then 16'h0522. pndng=0 after the second pop, tx_err=0.
3. id=3, filter on; bus pushes 16'h03AA, 16'h07BB, 16'hFFCC -> RX holds 16'h03AA then 16'hFFCC, and 16'h07BB is ignored. Filter off: all three are stored.
4. Fill RX with 8 packets for id, push 2 more with host_pop=0 -> rx_drop_cnt=2. Then push while host_pop=1 -> packet stored, rx_drop_cnt stays 2.
5. TX full (8 entries), host_push and pop in the same cycle -> tx_full stays 1, tx_err=0, and the new data emerges as the 8th subsequent D_pop. A pop on empty TX sets tx_err=1.
6. Reset asserted mid-stream with 5 TX and 3 RX entries -> pndng=0 and rx_empty=1 immediately (asynchronous), with no stale data after release.
